// File: rtl/stream_pkg.sv
// Shared definitions for ready/valid stream blocks: transfer polarity,
// transfer classification and the occupancy-counter width helper.
package stream_pkg;

  // A transfer happens on an edge where both handshake signals are at these levels.
  localparam logic XFER_VALID = 1'b1;
  localparam logic XFER_READY = 1'b1;

  // Per-cycle buffer activity, encoded as {push, pop}.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_POP  = 2'b01,
    XFER_PUSH = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_op_e;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True when a ready/valid pair completes a transfer this cycle.
  function automatic logic xfer(input logic valid, input logic ready);
    return (valid == XFER_VALID) && (ready == XFER_READY);
  endfunction

endpackage

// File: rtl/elastic_buffer_if.sv
// Upstream and downstream ready/valid handshake of the elastic buffer.
// slave: the buffer itself; master: the environment driving and consuming it.
interface elastic_buffer_if #(
  parameter int WIDTH = 32
);
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] input_data;
  logic             output_valid;
  logic             output_ready;
  logic [WIDTH-1:0] output_data;

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data
  );

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data
  );
endinterface

// File: rtl/elastic_buffer_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset; only control state is.
module elastic_buffer_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the accepted payload at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/elastic_buffer.sv
// Ready/valid elastic buffer (FIFO) with registered handshake flags.
// input_ready/output_valid/count/almost_full are all computed from the next
// occupancy and registered, so no input port reaches them combinationally.
// Head data is read straight from storage at the registered read pointer,
// giving zero-bubble latency. DEPTH=2 reproduces the classic skid buffer.
module elastic_buffer
  import stream_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  elastic_buffer_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t     wr_ptr_r;
  ptr_t     rd_ptr_r;
  cnt_t     count_r;
  logic     in_ready_r;
  logic     out_valid_r;
  logic     almost_full_r;

  logic     push_s;
  logic     pop_s;
  logic     wr_en_s;
  xfer_op_e op_s;
  ptr_t     wr_ptr_next_s;
  ptr_t     rd_ptr_next_s;
  cnt_t     count_next_s;

  // Classify this cycle's transfers and derive next pointers and occupancy.
  // Flush wins over both push and pop; pointers wrap by natural overflow.
  always_comb begin
    push_s        = xfer(bus.input_valid, in_ready_r);
    pop_s         = xfer(out_valid_r, bus.output_ready);
    op_s          = xfer_op_e'({push_s, pop_s});
    wr_en_s       = 1'b0;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (flush) begin
      wr_ptr_next_s = ptr_t'(0);
      rd_ptr_next_s = ptr_t'(0);
      count_next_s  = cnt_t'(0);
    end else begin
      case (op_s)
        XFER_PUSH: begin
          wr_en_s       = 1'b1;
          wr_ptr_next_s = wr_ptr_r + ptr_t'(1);
          count_next_s  = count_r + cnt_t'(1);
        end
        XFER_POP: begin
          rd_ptr_next_s = rd_ptr_r + ptr_t'(1);
          count_next_s  = count_r - cnt_t'(1);
        end
        XFER_BOTH: begin
          wr_en_s       = 1'b1;
          wr_ptr_next_s = wr_ptr_r + ptr_t'(1);
          rd_ptr_next_s = rd_ptr_r + ptr_t'(1);
        end
        default: begin
          count_next_s = count_r;
        end
      endcase
    end
  end

  // Control state register; flags are precomputed from next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= ptr_t'(0);
      rd_ptr_r      <= ptr_t'(0);
      count_r       <= cnt_t'(0);
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_next_s;
      rd_ptr_r      <= rd_ptr_next_s;
      count_r       <= count_next_s;
      in_ready_r    <= (count_next_s < cnt_t'(DEPTH));
      out_valid_r   <= (count_next_s != cnt_t'(0));
      almost_full_r <= (count_next_s >= cnt_t'(ALMOST_FULL));
    end
  end

  elastic_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s & ~reset),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.input_data),
    .rd_addr (rd_ptr_r),
    .rd_data (bus.output_data)
  );

  assign bus.input_ready  = in_ready_r;
  assign bus.output_valid = out_valid_r;
  assign count            = count_r;
  assign almost_full      = almost_full_r;

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer (WIDTH=8, DEPTH=4, ALMOST_FULL=3).
// Stimulus pushes expected bytes into a queue using a small occupancy model;
// a negedge monitor pops and compares whenever the DUT completes an output.
module tb_elastic_buffer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;

  elastic_buffer_if #(.WIDTH(8)) bus ();

  elastic_buffer #(
    .WIDTH       (8),
    .DEPTH       (4),
    .ALMOST_FULL (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .count       (count),
    .almost_full (almost_full)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         mdl_count = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic fl, input logic rst);
    logic push;
    logic pop;
    bus.input_valid  = iv;
    bus.input_data   = d;
    bus.output_ready = ordy;
    flush            = fl;
    reset            = rst;
    push = iv && (mdl_count < 4);
    pop  = ordy && (mdl_count != 0);
    if (rst || fl) begin
      exp_q.delete();
      mdl_count = 0;
    end else begin
      if (push) exp_q.push_back(d);
      mdl_count = mdl_count + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, int'(bus.input_ready), 1);
    chk({tag, "_valid"}, int'(bus.output_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_afull"}, int'(almost_full), 0);
  endtask

  // Monitor: every completed output transfer must match the scoreboard head.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (!reset && bus.output_valid && bus.output_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got %02h expected none", bus.output_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(bus.output_data), int'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.input_valid  = 1'b0;
    bus.input_data   = 8'h00;
    bus.output_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");

    // Fill
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("fill1_count", int'(count), 1);
    chk("fill1_afull", int'(almost_full), 0);
    chk("fill1_valid", int'(bus.output_valid), 1);
    chk("fill1_data", int'(bus.output_data), 8'h11);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("fill2_count", int'(count), 2);
    chk("fill2_afull", int'(almost_full), 0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("fill3_count", int'(count), 3);
    chk("fill3_afull", int'(almost_full), 1);
    chk("fill3_ready", int'(bus.input_ready), 1);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("fill4_count", int'(count), 4);
    chk("fill4_ready", int'(bus.input_ready), 0);
    chk("fill4_afull", int'(almost_full), 1);
    chk("fill4_data", int'(bus.output_data), 8'h11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("stall_data", int'(bus.output_data), 8'h11);
    chk("stall_valid", int'(bus.output_valid), 1);

    // Drain
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_valid", int'(bus.output_valid), 0);
    chk("drain_count", int'(count), 0);

    // Streaming: one transfer per cycle, occupancy holds at 1
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_count", int'(count), 1);
      chk("stream_valid", int'(bus.output_valid), 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stream_end_valid", int'(bus.output_valid), 0);

    // Full plus pop: 0x55 refused while full, accepted next cycle
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpop_count", int'(count), 3);
    chk("fullpop_ready", int'(bus.input_ready), 1);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpop2_count", int'(count), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fullpop_end_count", int'(count), 0);

    // Wrap: pointers cycle through all slots repeatedly
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) step(1'b1, 8'(r * 16 + k), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_count", int'(count), 0);

    // Flush with data offered in the same cycle
    step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    chk("preflush_count", int'(count), 2);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk_idle("flush");
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("postflush_valid", int'(bus.output_valid), 0);

    // Reset mid-stream
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b1, 1'b1);
    chk_idle("midreset");
    step(1'b1, 8'h79, 1'b1, 1'b0, 1'b1);
    chk_idle("midreset2");
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("postreset_valid", int'(bus.output_valid), 0);

    // Buffer still works after reset
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h9A, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("final_count", int'(count), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
